// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared register indices, limits and priority helper for int_ctrl
package int_ctrl_pkg;

    localparam int INT_MAX_SRC = 31;

    typedef enum logic [1:0] {
        INT_REG_PENDING = 2'd0,
        INT_REG_ENABLE  = 2'd1,
        INT_REG_EDGE    = 2'd2,
        INT_REG_CLAIM   = 2'd3
    } int_reg_e;

    // Returns (lowest set bit index)+1, or 0 when no bit is set.
    function automatic logic [4:0] int_lowest_id(input logic [INT_MAX_SRC-1:0] vec);
        logic [4:0] id;
        id = 5'd0;
        for (int i = INT_MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = 5'(i + 1);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/int_gateway.sv
// rtl/int_gateway.sv - per-source input stage, edge history and pending flop (INT_CTRL_SYNC_EN adds a second sync flop)
module int_gateway (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic edge_mode,
    input  logic in_service,
    input  logic clear,
    output logic pending
);

    logic sync_q;
    logic hist_q;
    logic rise;

`ifdef INT_CTRL_SYNC_EN
    logic meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= src;
            sync_q <= meta_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= src;
        end
    end
`endif

    assign rise = sync_q & ~hist_q;

    // History runs in both modes so a mode switch never fabricates an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q  <= 1'b0;
            pending <= 1'b0;
        end else begin
            hist_q <= sync_q;
            if (edge_mode) begin
                if (rise) begin
                    pending <= 1'b1;
                end else if (clear) begin
                    pending <= 1'b0;
                end
            end else if (clear) begin
                pending <= 1'b0;
            end else if (!in_service) begin
                pending <= sync_q;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - external interrupt controller: gateways, enables, claim/complete and request output (option INT_CTRL_SYNC_EN)
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    input  logic [3:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    input  logic               bus_wen,
    input  logic               bus_ren,
    output logic [31:0]        bus_rdata,
    output logic               external_int
);

    int_reg_e               sel;
    logic                   wr;
    logic                   rd;
    logic [NUM_SRC-1:0]     pending;
    logic [NUM_SRC-1:0]     enable_q;
    logic [NUM_SRC-1:0]     edge_q;
    logic [NUM_SRC-1:0]     in_service_q;
    logic [NUM_SRC-1:0]     claimable;
    logic [INT_MAX_SRC-1:0] claimable_w;
    logic [4:0]             claim_id;
    logic                   claim_fire;
    logic [NUM_SRC-1:0]     claim_mask;
    logic [NUM_SRC-1:0]     complete_mask;
    logic [NUM_SRC-1:0]     clear;
    logic [31:0]            rd_word;
    logic                   unused_addr;

    assign unused_addr = ^bus_addr[1:0];
    assign sel         = int_reg_e'(bus_addr[3:2]);
    assign wr          = bus_wen;
    assign rd          = bus_ren & ~bus_wen;
    assign claimable   = pending & enable_q & ~in_service_q;

    always_comb begin
        claimable_w                = '0;
        claimable_w[NUM_SRC-1:0]   = claimable;
    end

    assign claim_id   = int_lowest_id(claimable_w);
    assign claim_fire = rd && (sel == INT_REG_CLAIM) && (claim_id != 5'd0);

    // Claim and W1C share the gateway clear; the gateway lets a fresh edge win.
    always_comb begin
        claim_mask    = '0;
        complete_mask = '0;
        clear         = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_mask[i]    = claim_fire && (claim_id == 5'(i + 1));
            complete_mask[i] = wr && (sel == INT_REG_CLAIM) && (bus_wdata == 32'(i + 1));
            clear[i]         = claim_mask[i] ||
                               (wr && (sel == INT_REG_PENDING) && bus_wdata[i] && edge_q[i]);
        end
    end

    always_comb begin
        rd_word = '0;
        case (sel)
            INT_REG_PENDING: rd_word[NUM_SRC-1:0] = pending;
            INT_REG_ENABLE:  rd_word[NUM_SRC-1:0] = enable_q;
            INT_REG_EDGE:    rd_word[NUM_SRC-1:0] = edge_q;
            INT_REG_CLAIM:   rd_word[4:0]         = claim_id;
            default:         rd_word              = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q     <= '0;
            edge_q       <= '0;
            in_service_q <= '0;
            bus_rdata    <= '0;
            external_int <= 1'b0;
        end else begin
            if (wr && (sel == INT_REG_ENABLE)) begin
                enable_q <= bus_wdata[NUM_SRC-1:0];
            end
            if (wr && (sel == INT_REG_EDGE)) begin
                edge_q <= bus_wdata[NUM_SRC-1:0];
            end
            in_service_q <= (in_service_q & ~complete_mask) | claim_mask;
            if (rd) begin
                bus_rdata <= rd_word;
            end
            external_int <= |claimable;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
        int_gateway u_gw (
            .clk        (clk),
            .rst        (rst),
            .src        (src[g]),
            .edge_mode  (edge_q[g]),
            .in_service (in_service_q[g]),
            .clear      (clear[g]),
            .pending    (pending[g])
        );
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed vector table, corner sequences and randomized model check for int_ctrl
module tb_int_ctrl;

    localparam int N = 8;
`ifdef INT_CTRL_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int DEPTH = LAT - 2;

    localparam logic [3:0] A_PEND  = 4'h0;
    localparam logic [3:0] A_EN    = 4'h4;
    localparam logic [3:0] A_EDGE  = 4'h8;
    localparam logic [3:0] A_CLAIM = 4'hC;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] src = '0;
    logic [3:0]   addr = '0;
    logic [31:0]  wdata = '0;
    logic         wen = 1'b0;
    logic         ren = 1'b0;
    logic [31:0]  rdata;
    logic         ext;

    int total = 0;
    int bad   = 0;
    logic [N-1:0] cur_src = '0;

    always #5 clk = ~clk;

    int_ctrl #(.NUM_SRC(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .src          (src),
        .bus_addr     (addr),
        .bus_wdata    (wdata),
        .bus_wen      (wen),
        .bus_ren      (ren),
        .bus_rdata    (rdata),
        .external_int (ext)
    );

    typedef struct {
        logic         we;
        logic         re;
        logic [3:0]   a;
        logic [31:0]  wd;
        logic [N-1:0] s;
        logic         chk_rd;
        logic [31:0]  exp_rd;
        logic         chk_int;
        logic         exp_int;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic we, logic re, logic [3:0] a, logic [31:0] wd, logic [N-1:0] s,
                               logic cr, logic [31:0] er, logic ci, logic ei);
        vec_t r;
        r.we = we; r.re = re; r.a = a; r.wd = wd; r.s = s;
        r.chk_rd = cr; r.exp_rd = er; r.chk_int = ci; r.exp_int = ei;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic we, input logic re, input logic [3:0] a,
                        input logic [31:0] wd, input logic [N-1:0] s);
        @(negedge clk);
        rst = r; wen = we; ren = re; addr = a; wdata = wd; src = s;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b0, a, d, cur_src);
    endtask

    task automatic rdreg(input logic [3:0] a);
        step(1'b0, 1'b0, 1'b1, a, 32'd0, cur_src);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 4'h0, 32'd0, cur_src);
    endtask

    task automatic do_reset();
        cur_src = '0;
        step(1'b1, 1'b0, 1'b0, 4'h0, 32'd0, '0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 32'd0, '0);
    endtask

    // Reference model: src history line, per-source pending/enable/edge/in-service bits.
    logic [N-1:0] line [0:2];
    bit   m_en [N], m_edge [N], m_ins [N], m_pend [N];
    logic [31:0]  m_rd;
    logic         m_ext;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_en[i] = 0; m_edge[i] = 0; m_ins[i] = 0; m_pend[i] = 0;
        end
        for (int k = 0; k < 3; k++) line[k] = '0;
        m_rd = 0; m_ext = 0;
    endtask

    task automatic model_step(input logic r, input logic we, input logic re, input logic [3:0] a,
                              input logic [31:0] wd, input logic [N-1:0] s);
        int   reg_idx, id, any;
        bit   do_rd, clr, cur, prev;
        bit   new_pend [N];
        if (r) begin
            model_reset();
            return;
        end
        reg_idx = int'(a[3:2]);
        do_rd   = re && !we;
        id = 0; any = 0;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && m_en[i] && !m_ins[i]) begin
                any = 1;
                if (id == 0) id = i + 1;
            end
        end
        if (do_rd) begin
            m_rd = 0;
            for (int i = 0; i < N; i++) begin
                if (reg_idx == 0) m_rd[i] = m_pend[i];
                if (reg_idx == 1) m_rd[i] = m_en[i];
                if (reg_idx == 2) m_rd[i] = m_edge[i];
            end
            if (reg_idx == 3) m_rd = id;
        end
        for (int i = 0; i < N; i++) begin
            cur  = line[DEPTH-1][i];
            prev = line[DEPTH][i];
            clr  = (do_rd && reg_idx == 3 && id == i + 1) ||
                   (we && reg_idx == 0 && wd[i] && m_edge[i]);
            if (m_edge[i]) new_pend[i] = (cur && !prev) ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
            else           new_pend[i] = clr ? 1'b0 : (m_ins[i] ? m_pend[i] : cur);
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = new_pend[i];
            if (do_rd && reg_idx == 3 && id == i + 1) m_ins[i] = 1;
            if (we && reg_idx == 3 && wd == i + 1) m_ins[i] = 0;
            if (we && reg_idx == 1) m_en[i] = wd[i];
            if (we && reg_idx == 2) m_edge[i] = wd[i];
        end
        m_ext   = (any != 0);
        line[2] = line[1];
        line[1] = line[0];
        line[0] = s;
    endtask

    initial begin
        int seen;
        logic         r, we, re;
        logic [3:0]   a;
        logic [31:0]  wd;
        logic [N-1:0] s;

        do_reset();
        check("reset_rdata", rdata, 32'd0);
        check("reset_int", {31'd0, ext}, 32'd0);

        tbl.push_back(v(0, 1, A_PEND,  0, 8'h00, 1, 32'h0, 1, 0));
        tbl.push_back(v(0, 1, A_EN,    0, 8'h00, 1, 32'h0, 1, 0));
        tbl.push_back(v(0, 1, A_EDGE,  0, 8'h00, 1, 32'h0, 1, 0));
        tbl.push_back(v(0, 1, A_CLAIM, 0, 8'h00, 1, 32'h0, 1, 0));
        tbl.push_back(v(1, 0, A_EN,    1, 8'h00, 0, 32'h0, 1, 0));
        tbl.push_back(v(1, 0, A_EDGE,  1, 8'h00, 0, 32'h0, 1, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h01, 0, 32'h0, 1, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h00, 0, 32'h0, 0, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h00, 0, 32'h0, 0, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h00, 0, 32'h0, 1, 1));
        tbl.push_back(v(0, 1, A_CLAIM, 0, 8'h00, 1, 32'h1, 1, 1));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h00, 0, 32'h0, 1, 0));
        tbl.push_back(v(0, 1, A_PEND,  0, 8'h00, 1, 32'h0, 1, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h01, 0, 32'h0, 1, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h00, 0, 32'h0, 1, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h00, 0, 32'h0, 1, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h00, 0, 32'h0, 1, 0));
        tbl.push_back(v(0, 1, A_PEND,  0, 8'h00, 1, 32'h1, 1, 0));
        tbl.push_back(v(1, 0, A_CLAIM, 1, 8'h00, 0, 32'h0, 1, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h00, 0, 32'h0, 1, 1));
        tbl.push_back(v(0, 1, A_CLAIM, 0, 8'h00, 1, 32'h1, 1, 1));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h00, 0, 32'h0, 1, 0));
        tbl.push_back(v(1, 0, A_EN,    32'h0C, 8'h00, 0, 32'h0, 1, 0));
        tbl.push_back(v(1, 0, A_EDGE,  0, 8'h0C, 0, 32'h0, 0, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h0C, 0, 32'h0, 0, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h0C, 0, 32'h0, 0, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h0C, 0, 32'h0, 1, 1));
        tbl.push_back(v(0, 1, A_CLAIM, 0, 8'h0C, 1, 32'h3, 1, 1));
        tbl.push_back(v(0, 1, A_CLAIM, 0, 8'h0C, 1, 32'h4, 1, 1));
        tbl.push_back(v(0, 1, A_CLAIM, 0, 8'h0C, 1, 32'h0, 1, 0));
        tbl.push_back(v(1, 0, A_CLAIM, 3, 8'h0C, 0, 32'h0, 1, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h0C, 0, 32'h0, 0, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h0C, 0, 32'h0, 1, 1));
        tbl.push_back(v(0, 1, A_CLAIM, 0, 8'h0C, 1, 32'h3, 0, 0));
        tbl.push_back(v(1, 0, A_CLAIM, 3, 8'h0C, 0, 32'h0, 0, 0));
        tbl.push_back(v(1, 0, A_CLAIM, 4, 8'h00, 0, 32'h0, 0, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h00, 0, 32'h0, 0, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h00, 0, 32'h0, 0, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h00, 0, 32'h0, 0, 0));
        tbl.push_back(v(0, 1, A_PEND,  0, 8'h00, 1, 32'h0, 1, 0));
        tbl.push_back(v(1, 0, A_EN,    32'hFFFF_FFFF, 8'h00, 0, 32'h0, 0, 0));
        tbl.push_back(v(0, 1, A_EN,    0, 8'h00, 1, 32'hFF, 0, 0));
        tbl.push_back(v(1, 0, A_EDGE,  32'hFFFF_FFFF, 8'h00, 0, 32'h0, 0, 0));
        tbl.push_back(v(0, 1, A_EDGE,  0, 8'h00, 1, 32'hFF, 0, 0));
        tbl.push_back(v(1, 0, A_CLAIM, 0, 8'h00, 0, 32'h0, 0, 0));
        tbl.push_back(v(1, 0, A_CLAIM, 9, 8'h00, 0, 32'h0, 0, 0));
        tbl.push_back(v(1, 1, A_EN,    1, 8'h00, 1, 32'hFF, 0, 0));
        tbl.push_back(v(0, 1, A_EN,    0, 8'h00, 1, 32'h01, 0, 0));
        tbl.push_back(v(0, 0, A_PEND,  0, 8'h00, 1, 32'h01, 1, 0));

        foreach (tbl[k]) begin
            step(1'b0, tbl[k].we, tbl[k].re, tbl[k].a, tbl[k].wd, tbl[k].s);
            if (tbl[k].chk_rd)  check($sformatf("vec%0d_rdata", k), rdata, tbl[k].exp_rd);
            if (tbl[k].chk_int) check($sformatf("vec%0d_int", k), {31'd0, ext}, {31'd0, tbl[k].exp_int});
        end

        // Source-to-request latency, counted from the edge that samples the pulse.
        do_reset();
        wr(A_EN, 1);
        wr(A_EDGE, 1);
        cur_src = 8'h01;
        idle(1);
        cur_src = 8'h00;
        seen = ext ? 1 : 0;
        for (int k = 2; k <= 10; k++) begin
            idle(1);
            if (ext && seen == 0) seen = k;
        end
        check("latency", 32'(seen), 32'(LAT));
        rdreg(A_CLAIM);
        check("lat_claim", rdata, 32'd1);
        idle(1);
        check("lat_drop", {31'd0, ext}, 32'd0);

        // Edge set lands on the same edge as a W1C; source disabled meanwhile.
        do_reset();
        wr(A_EDGE, 1);
        cur_src = 8'h01;
        idle(1);
        cur_src = 8'h00;
        if (DEPTH == 2) idle(1);
        wr(A_PEND, 1);
        idle(2);
        rdreg(A_PEND);
        check("w1c_race_pend", rdata, 32'd1);
        check("disabled_int", {31'd0, ext}, 32'd0);
        rdreg(A_CLAIM);
        check("disabled_claim", rdata, 32'd0);
        wr(A_EN, 1);
        idle(1);
        check("enable_reveal", {31'd0, ext}, 32'd1);
        wr(A_PEND, 1);
        rdreg(A_PEND);
        check("w1c_clear", rdata, 32'd0);

        // Reset coinciding with a claim read of source 2.
        do_reset();
        wr(A_EN, 2);
        wr(A_EDGE, 2);
        cur_src = 8'h02;
        idle(1);
        cur_src = 8'h00;
        idle(3);
        rdreg(A_PEND);
        check("pre_reset_pend", rdata, 32'd2);
        step(1'b1, 1'b0, 1'b1, A_CLAIM, 32'd0, '0);
        check("rst_claim_rdata", rdata, 32'd0);
        check("rst_claim_int", {31'd0, ext}, 32'd0);
        rdreg(A_PEND);
        check("rst_claim_pend", rdata, 32'd0);
        wr(A_EN, 2);
        cur_src = 8'h02;
        idle(4);
        rdreg(A_CLAIM);
        check("rst_claim_insvc", rdata, 32'd2);

        // Randomized traffic against the reference model.
        cur_src = '0;
        model_reset();
        step(1'b1, 1'b0, 1'b0, 4'h0, 32'd0, '0);
        for (int k = 0; k < 3000; k++) begin
            r  = ($urandom_range(0, 299) == 0);
            we = ($urandom_range(0, 3) == 0);
            re = ($urandom_range(0, 2) == 0);
            a  = 4'($urandom_range(0, 15));
            if (a[3:2] == 2'd3) wd = 32'($urandom_range(0, 10));
            else                wd = $urandom;
            cur_src = cur_src ^ (N'($urandom) & N'($urandom) & N'($urandom));
            s = cur_src;
            step(r, we, re, a, wd, s);
            model_step(r, we, re, a, wd, s);
            check($sformatf("rand%0d_rdata", k), rdata, m_rd);
            check($sformatf("rand%0d_int", k), {31'd0, ext}, {31'd0, m_ext});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
